// File: rtl/mem_sys_ram_pkg.sv
// -----------------------------------------------------------------------------
// mem_sys_ram_pkg
// Shared constants and types for the 6502 system main-memory RAM.
//   REG_WIDTH  : CPU register / memory word width
//   ADDR_WIDTH : CPU address bus width
//   MEM_DEPTH  : number of words in the RAM array
//   MEM_FLAT_W : width of the flat preload / monitor bus
// -----------------------------------------------------------------------------
package mem_sys_ram_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;
    localparam int MEM_DEPTH  = 256;
    localparam int MEM_FLAT_W = MEM_DEPTH * REG_WIDTH;

    typedef logic [REG_WIDTH-1:0] mem_word_t;

    // Extract word idx from a flat image using the shared packing
    // (word i lives in bits [i*REG_WIDTH +: REG_WIDTH]).
    function automatic mem_word_t flat_word(input logic [MEM_FLAT_W-1:0] flat,
                                            input int unsigned           idx);
        return flat[idx*REG_WIDTH +: REG_WIDTH];
    endfunction

endpackage

// File: rtl/mem_sys_ram_if.sv
// -----------------------------------------------------------------------------
// mem_sys_ram_if
// CPU-side access bus of the main-memory RAM.
//   we       : write enable (master -> slave)
//   din      : write data   (master -> slave)
//   addr     : word address (master -> slave)
//   dout     : registered read data        (slave -> master)
//   addr_err : registered out-of-range flag (slave -> master)
// Modports: master (CPU / bench), slave (RAM).
// -----------------------------------------------------------------------------
interface mem_sys_ram_if #(
    parameter int WIDTH      = mem_sys_ram_pkg::REG_WIDTH,
    parameter int ADDR_WIDTH = mem_sys_ram_pkg::ADDR_WIDTH
);
    logic                  we;
    logic [WIDTH-1:0]      din;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      dout;
    logic                  addr_err;

    modport master (output we, output din, output addr,
                    input  dout, input addr_err);

    modport slave  (input  we, input din, input addr,
                    output dout, output addr_err);

endinterface

// File: rtl/mem_sys_ram.sv
// -----------------------------------------------------------------------------
// mem_sys_ram
// Single-port synchronous byte RAM used as main memory of the 6502 system.
// Read-first on writes, one-cycle registered read latency, no address wrap.
//
// Ports:
//   clk             : single clock, all state changes on the rising edge
//   reset           : synchronous, active-high; clears dout/addr_err
//   bus (slave)     : we / din / addr in, dout / addr_err out
//   override_mem    : bench-only whole-array load from mem_override_in
//   mem_override_in : flat preload image, word i at [i*WIDTH +: WIDTH]
//   mem_monitor     : flat combinational view of the array, same packing
//
// Edge priority: override_mem > reset > normal access.
//
// Build option: define MEM_CLEAR_ON_RESET_EN to also zero the array on a
// reset edge that has no override; by default the array survives reset.
// -----------------------------------------------------------------------------
module mem_sys_ram #(
    parameter int DEPTH      = mem_sys_ram_pkg::MEM_DEPTH,
    parameter int WIDTH      = mem_sys_ram_pkg::REG_WIDTH,
    parameter int ADDR_WIDTH = mem_sys_ram_pkg::ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_sys_ram_if.slave           bus,
    input  logic                   override_mem,
    input  logic [DEPTH*WIDTH-1:0] mem_override_in,
    output logic [DEPTH*WIDTH-1:0] mem_monitor
);

    import mem_sys_ram_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r      [DEPTH];
    logic [WIDTH-1:0] ovr_word_s [DEPTH];
    logic [WIDTH-1:0] rd_word_s;
    logic [WIDTH-1:0] ovr_rd_s;
    logic [IDX_W-1:0] idx_s;
    logic             in_range_s;
    logic [WIDTH-1:0] dout_r;
    logic             addr_err_r;

    // Unpack the preload image and pack the array onto the monitor bus.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign ovr_word_s[gi]                 = mem_override_in[gi*WIDTH +: WIDTH];
        assign mem_monitor[gi*WIDTH +: WIDTH] = mem_r[gi];
    end

    // Address decode: range check and the array index it guards.
    always_comb begin
        in_range_s = ({1'b0, bus.addr} < DEPTH_EXT);
        idx_s      = bus.addr[IDX_W-1:0];
    end

    // Read muxes for the array and for the preload image; out of range reads 0.
    always_comb begin
        rd_word_s = '0;
        ovr_rd_s  = '0;
        if (in_range_s) begin
            rd_word_s = mem_r[idx_s];
            ovr_rd_s  = ovr_word_s[idx_s];
        end else begin
            rd_word_s = '0;
            ovr_rd_s  = '0;
        end
    end

    // Array update: override loads everything, reset blocks writes, else write.
    always_ff @(posedge clk) begin
        if (override_mem) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ovr_word_s[i];
            end
        end else if (reset) begin
`ifdef MEM_CLEAR_ON_RESET_EN
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
`endif
        end else if (bus.we && in_range_s) begin
            mem_r[idx_s] <= bus.din;
        end
    end

    // Registered read data and range flag; read-first because mem_r is the
    // pre-edge value.
    always_ff @(posedge clk) begin
        if (override_mem) begin
            dout_r     <= ovr_rd_s;
            addr_err_r <= 1'b0;
        end else if (reset) begin
            dout_r     <= '0;
            addr_err_r <= 1'b0;
        end else begin
            dout_r     <= rd_word_s;
            addr_err_r <= ~in_range_s;
        end
    end

    assign bus.dout     = dout_r;
    assign bus.addr_err = addr_err_r;

endmodule

// File: tb/tb_mem_sys_ram.sv
// -----------------------------------------------------------------------------
// tb_mem_sys_ram
// Self-checking bench for mem_sys_ram. A behavioural memory model predicts
// dout/addr_err for every driven cycle; predictions are queued at drive time
// and popped after the edge for comparison. mem_monitor is compared word by
// word against the model at key points.
// -----------------------------------------------------------------------------
module tb_mem_sys_ram;

    import mem_sys_ram_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  override_mem;
    logic [MEM_FLAT_W-1:0] mem_override_in;
    logic [MEM_FLAT_W-1:0] mem_monitor;

    mem_sys_ram_if #(.WIDTH(REG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus_if ();

    mem_sys_ram #(
        .DEPTH      (MEM_DEPTH),
        .WIDTH      (REG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_if.slave),
        .override_mem    (override_mem),
        .mem_override_in (mem_override_in),
        .mem_monitor     (mem_monitor)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_err = 0;
    mem_word_t model [MEM_DEPTH];
    mem_word_t img   [MEM_DEPTH];
    mem_word_t exp_dout_q [$];
    logic      exp_err_q  [$];
    string     tag_q      [$];

    // Single comparison point: counts and reports a mismatch.
    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pack the image array onto the override bus.
    task automatic load_image();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_override_in[i*REG_WIDTH +: REG_WIDTH] = img[i];
        end
    endtask

    // Drive one edge, predict from the model, then compare the registered outputs.
    task automatic step(input logic ov, input logic rst, input logic wr,
                        input logic [15:0] a, input mem_word_t d, input string tag);
        mem_word_t e_dout;
        logic      e_err;
        logic      inr;
        inr = (a < 16'(MEM_DEPTH));
        if (ov) begin
            e_dout = inr ? img[a[7:0]] : 8'h00;
            e_err  = 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) model[i] = img[i];
        end else if (rst) begin
            e_dout = 8'h00;
            e_err  = 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
            for (int i = 0; i < MEM_DEPTH; i++) model[i] = 8'h00;
`endif
        end else begin
            e_dout = inr ? model[a[7:0]] : 8'h00;
            e_err  = ~inr;
            if (wr && inr) model[a[7:0]] = d;
        end
        exp_dout_q.push_back(e_dout);
        exp_err_q.push_back(e_err);
        tag_q.push_back(tag);

        override_mem = ov;
        reset        = rst;
        bus_if.we    = wr;
        bus_if.addr  = a;
        bus_if.din   = d;
        @(posedge clk);
        #1;
        begin
            string t;
            t = tag_q.pop_front();
            chk_eq({t, "_dout"}, 32'(bus_if.dout), 32'(exp_dout_q.pop_front()));
            chk_eq({t, "_err"},  32'(bus_if.addr_err), 32'(exp_err_q.pop_front()));
        end
    endtask

    // Compare the whole monitor bus against the model.
    task automatic chk_monitor(input string tag);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            chk_eq(tag, 32'(flat_word(mem_monitor, i)), 32'(model[i]));
        end
    endtask

    initial begin
        override_mem    = 1'b0;
        reset           = 1'b1;
        bus_if.we       = 1'b0;
        bus_if.addr     = 16'h0000;
        bus_if.din      = 8'h00;
        mem_override_in = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            img[i]   = 8'(i) ^ 8'hA5;
            model[i] = 8'h00;
        end
        load_image();
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        step(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, "rst");

        // 1. Preload under reset, then read 0x10.
        step(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, "t1_ovr");
        chk_eq("t1_mon00", 32'(flat_word(mem_monitor, 0)),  32'h0000_00A5);
        chk_eq("t1_mon10", 32'(flat_word(mem_monitor, 16)), 32'h0000_00B5);
        chk_monitor("t1_mon");
        step(1'b0, 1'b0, 1'b0, 16'h0010, 8'h00, "t1_rd10");
        chk_eq("t1_b5", 32'(bus_if.dout), 32'h0000_00B5);

        // 2. Read-first write, then read back.
        step(1'b0, 1'b0, 1'b1, 16'h0020, 8'h3C, "t2_wr");
        chk_eq("t2_old", 32'(bus_if.dout), 32'h0000_0085);
        chk_eq("t2_mon_now", 32'(flat_word(mem_monitor, 32)), 32'h0000_003C);
        step(1'b0, 1'b0, 1'b0, 16'h0020, 8'h00, "t2_rd");
        chk_eq("t2_new", 32'(bus_if.dout), 32'h0000_003C);

        // 3. Out of range write and read, then flag clears.
        step(1'b0, 1'b0, 1'b1, 16'h0100, 8'hFF, "t3_wr_oor");
        chk_eq("t3_err", 32'(bus_if.addr_err), 32'h0000_0001);
        chk_monitor("t3_mon");
        step(1'b0, 1'b0, 1'b0, 16'h0100, 8'h00, "t3_rd_oor");
        step(1'b0, 1'b0, 1'b0, 16'hFFFF, 8'h00, "t3_rd_top");
        step(1'b0, 1'b0, 1'b0, 16'h00FF, 8'h00, "t3_rd_last");

        // 4. Reset mid-stream swallows a write.
        step(1'b0, 1'b0, 1'b1, 16'h0006, 8'h5A, "t4_pre");
        step(1'b0, 1'b1, 1'b1, 16'h0005, 8'h77, "t4_rst");
        chk_monitor("t4_mon");
        step(1'b0, 1'b0, 1'b0, 16'h0005, 8'h00, "t4_rd05");

        // 5. Override beats a same-edge write.
        img[7] = 8'h99;
        load_image();
        step(1'b1, 1'b0, 1'b1, 16'h0007, 8'h11, "t5_ovr");
        chk_eq("t5_dout99", 32'(bus_if.dout), 32'h0000_0099);
        chk_eq("t5_mon07", 32'(flat_word(mem_monitor, 7)), 32'h0000_0099);
        step(1'b0, 1'b0, 1'b0, 16'h0007, 8'h00, "t5_rd07");

        // 6. Back-to-back writes then reads.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'(i), 8'(8'hC0 + 8'(i * 3)), $sformatf("t6_wr%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'(i), 8'h00, $sformatf("t6_rd%0d", i));
        end
        chk_monitor("t6_mon");

        // Random mix of in-range and out-of-range traffic.
        for (int i = 0; i < 64; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                            : 16'($urandom_range(0, 255));
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                 $sformatf("rnd%0d", i));
        end
        chk_monitor("rnd_mon");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
